// File: rtl/nco_lut_reader.sv
// nco_lut_reader: numerically controlled oscillator front end.
// Advances a phase accumulator on every enabled cycle, issues one read per
// enabled cycle to the 256x16 waveform SRAM, and captures the returned word
// two edges later as a validated sample stream.
//
// Build option: define NCO_QUARTER_WAVE_EN when the SRAM holds a quarter sine
// wave. The two top phase bits then select the quadrant; odd quadrants read the
// table mirrored and the upper half-cycle negates the captured word. Latency
// is the same in both builds.
module nco_lut_reader #(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic               fcw_load,
    input  logic [PHASE_W-1:0] fcw_in,
    input  logic [PHASE_W-1:0] phase_off,
    output logic               ram_csb,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [DATA_W-1:0]  ram_dout,
    output logic [DATA_W-1:0]  sample_out,
    output logic               sample_valid
);

    logic [PHASE_W-1:0] acc_r;
    logic [PHASE_W-1:0] fcw_reg_r;
    logic [ADDR_W-1:0]  addr_next_s;
    logic [DATA_W-1:0]  capture_s;
    // High while the SRAM holds a registered read whose data is due at the next edge.
    logic               rd_pend_r;

`ifdef NCO_QUARTER_WAVE_EN
    localparam int LO_W = PHASE_W - ADDR_W - 2;

    logic [1:0]         quad_s;
    logic [ADDR_W-1:0]  idx_s;
    logic [LO_W-1:0]    phase_lo_unused_s;
    // Sign of the read being issued, then of the read the SRAM is serving.
    logic               neg_issue_r;
    logic               neg_pend_r;

    // Split the offset phase into quadrant and table index; mirror odd quadrants.
    always_comb begin
        {quad_s, idx_s, phase_lo_unused_s} = acc_r + phase_off;
        if (quad_s[0]) begin
            addr_next_s = ~idx_s;
        end else begin
            addr_next_s = idx_s;
        end
    end

    // Restore the sign of the upper half-cycle on the word being captured.
    always_comb begin
        if (neg_pend_r) begin
            capture_s = {DATA_W{1'b0}} - ram_dout;
        end else begin
            capture_s = ram_dout;
        end
    end

    // Carry the quadrant sign bit alongside the read through the SRAM stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_issue_r <= 1'b0;
            neg_pend_r  <= 1'b0;
        end else begin
            neg_pend_r <= neg_issue_r;
            if (!clr && en) begin
                neg_issue_r <= quad_s[1];
            end else begin
                neg_issue_r <= neg_issue_r;
            end
        end
    end
`else
    logic [PHASE_W-ADDR_W-1:0] phase_lo_unused_s;

    // Full-wave table: the top phase bits address the SRAM directly.
    always_comb begin
        {addr_next_s, phase_lo_unused_s} = acc_r + phase_off;
    end

    // Full-wave table: the SRAM word is the sample.
    always_comb begin
        capture_s = ram_dout;
    end
`endif

    // Tuning word register, phase accumulator and SRAM read request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcw_reg_r <= {PHASE_W{1'b0}};
            acc_r     <= {PHASE_W{1'b0}};
            ram_csb   <= 1'b1;
            ram_addr  <= {ADDR_W{1'b0}};
        end else begin
            if (fcw_load) begin
                fcw_reg_r <= fcw_in;
            end else begin
                fcw_reg_r <= fcw_reg_r;
            end

            // Clear wins over enable; reads already in the SRAM still complete.
            if (clr) begin
                acc_r    <= {PHASE_W{1'b0}};
                ram_csb  <= 1'b1;
                ram_addr <= ram_addr;
            end else if (en) begin
                acc_r    <= acc_r + fcw_reg_r;
                ram_csb  <= 1'b0;
                ram_addr <= addr_next_s;
            end else begin
                acc_r    <= acc_r;
                ram_csb  <= 1'b1;
                ram_addr <= ram_addr;
            end
        end
    end

    // Follow each read through the SRAM register stage and capture its data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_r    <= 1'b0;
            sample_valid <= 1'b0;
            sample_out   <= {DATA_W{1'b0}};
        end else begin
            rd_pend_r    <= ~ram_csb;
            sample_valid <= rd_pend_r;
            if (rd_pend_r) begin
                sample_out <= capture_s;
            end else begin
                sample_out <= sample_out;
            end
        end
    end

endmodule

// File: tb/tb_nco_lut_reader.sv
// tb_nco_lut_reader: bench for nco_lut_reader with a behavioural SRAM read port.
// Table-driven vectors with hand-computed expectations, plus a reference model
// whose predicted samples go through a scoreboard queue.
module tb_nco_lut_reader;

    localparam int PW = 24;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          clr;
    logic          fcw_load;
    logic [PW-1:0] fcw_in;
    logic [PW-1:0] phase_off;
    logic          ram_csb;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] sample_out;
    logic          sample_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nco_lut_reader #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clr          (clr),
        .fcw_load     (fcw_load),
        .fcw_in       (fcw_in),
        .phase_off    (phase_off),
        .ram_csb      (ram_csb),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    // SRAM read port: registers addr/csb at the edge, data after the falling edge,
    // garbage shortly after the following edge.
    logic [DW-1:0] mem [256];
    logic [AW-1:0] sram_addr_r = '0;
    logic          sram_act_r  = 1'b0;

    always @(posedge clk) begin
        sram_addr_r <= ram_addr;
        sram_act_r  <= !ram_csb;
    end

    initial ram_dout = 16'hDEAD;
    always begin
        @(negedge clk);
        ram_dout = sram_act_r ? mem[sram_addr_r] : 16'hDEAD;
        @(posedge clk);
        #1;
        ram_dout = 16'hDEAD;
    end

    // Reference model state
    logic [PW-1:0] m_acc, m_fcw;
    logic          m_csb, m_v0, m_v1;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_last;
    logic [DW-1:0] sb_q[$];

    function automatic logic [AW-1:0] ref_addr(input logic [PW-1:0] p);
`ifdef NCO_QUARTER_WAVE_EN
        logic [AW-1:0] idx;
        idx = p[PW-3 -: AW];
        return p[PW-2] ? ~idx : idx;
`else
        return p[PW-1 -: AW];
`endif
    endfunction

    function automatic logic [DW-1:0] ref_sample(input logic [PW-1:0] p);
        logic [DW-1:0] w;
        w = mem[ref_addr(p)];
`ifdef NCO_QUARTER_WAVE_EN
        if (p[PW-1]) w = 16'h0000 - w;
`endif
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, then check outputs 1 time unit later.
    task automatic tick();
        logic          exp_valid;
        logic [PW-1:0] p;
        @(posedge clk);
        if (!rst_n) begin
            m_acc = '0; m_fcw = '0; m_csb = 1'b1; m_addr = '0;
            m_v0 = 1'b0; m_v1 = 1'b0; m_last = '0; exp_valid = 1'b0;
            sb_q.delete();
        end else begin
            exp_valid = m_v1;
            m_v1 = m_v0;
            m_v0 = 1'b0;
            if (clr) begin
                m_acc = '0;
                m_csb = 1'b1;
            end else if (en) begin
                p = m_acc + phase_off;
                m_addr = ref_addr(p);
                m_csb = 1'b0;
                sb_q.push_back(ref_sample(p));
                m_acc = m_acc + m_fcw;
                m_v0 = 1'b1;
            end else begin
                m_csb = 1'b1;
            end
            if (fcw_load) m_fcw = fcw_in;
        end
        #1;
        chk("sb_csb", ram_csb, m_csb);
        chk("sb_addr", ram_addr, m_addr);
        chk("sb_valid", sample_valid, exp_valid);
        if (exp_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_queue_nonempty", 32'd0, 32'd1);
            end else begin
                m_last = sb_q.pop_front();
            end
        end
        chk("sb_sample", sample_out, m_last);
    endtask

    typedef struct {
        logic          en;
        logic          clr;
        logic          ld;
        logic [PW-1:0] fcw;
        logic [PW-1:0] off;
        logic          e_csb;
        logic [AW-1:0] e_addr;
        logic          e_vld;
        logic [DW-1:0] e_smp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic e, input logic c, input logic l,
                                input logic [PW-1:0] f, input logic [PW-1:0] o,
                                input logic cs, input logic [AW-1:0] a,
                                input logic v, input logic [DW-1:0] s);
        vec_t r;
        r.en = e; r.clr = c; r.ld = l; r.fcw = f; r.off = o;
        r.e_csb = cs; r.e_addr = a; r.e_vld = v; r.e_smp = s;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt, addr_wraps, smp_wraps;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_smp;
        logic          prev_v;

        for (int i = 0; i < 256; i++) begin
`ifdef NCO_QUARTER_WAVE_EN
            mem[i] = DW'(i);
`else
            mem[i] = DW'(i) * 16'h0101;
`endif
        end

`ifdef NCO_QUARTER_WAVE_EN
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 24'h000000, 24'h400000, 1'b1, 8'h00, 1'b0, 16'h0000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h000000, 24'h400000, 1'b0, 8'hFF, 1'b0, 16'h0000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h000000, 24'h400000, 1'b0, 8'hFF, 1'b0, 16'h0000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h000000, 24'hC00000, 1'b0, 8'hFF, 1'b1, 16'h00FF));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h000000, 24'h404000, 1'b0, 8'hFE, 1'b1, 16'h00FF));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h000000, 24'h404000, 1'b1, 8'hFE, 1'b1, 16'hFF01));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h000000, 24'h404000, 1'b1, 8'hFE, 1'b1, 16'h00FE));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h000000, 24'h404000, 1'b1, 8'hFE, 1'b0, 16'h00FE));
`else
        // Ramp at fcw 0x010000 with a gap in en
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 24'h010000, 24'h0, 1'b1, 8'h00, 1'b0, 16'h0000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 8'h00, 1'b0, 16'h0000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 8'h01, 1'b0, 16'h0000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 8'h02, 1'b1, 16'h0000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 8'h03, 1'b1, 16'h0101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 8'h04, 1'b1, 16'h0202));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b1, 8'h04, 1'b1, 16'h0303));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b1, 8'h04, 1'b1, 16'h0404));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 8'h05, 1'b0, 16'h0404));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 8'h06, 1'b0, 16'h0404));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b1, 8'h06, 1'b1, 16'h0505));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b1, 8'h06, 1'b1, 16'h0606));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b1, 8'h06, 1'b0, 16'h0606));
        // fcw 0x020000, offset 0x800000, en pattern 1,0,1,1
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 24'h020000, 24'h800000, 1'b1, 8'h06, 1'b0, 16'h0606));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h0, 24'h800000, 1'b0, 8'h80, 1'b0, 16'h0606));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h0, 24'h800000, 1'b1, 8'h80, 1'b0, 16'h0606));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h0, 24'h800000, 1'b0, 8'h82, 1'b1, 16'h8080));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 24'h0, 24'h800000, 1'b0, 8'h84, 1'b0, 16'h8080));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h0, 24'h800000, 1'b1, 8'h84, 1'b1, 16'h8282));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h0, 24'h800000, 1'b1, 8'h84, 1'b1, 16'h8484));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 24'h0, 24'h800000, 1'b1, 8'h84, 1'b0, 16'h8484));
`endif

        // Reset, then idle
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; fcw_load = 1'b0;
        fcw_in = '0; phase_off = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_csb", ram_csb, 1'b1);
            chk("idle_valid", sample_valid, 1'b0);
            chk("idle_sample", sample_out, 16'h0000);
        end

        // Table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; clr = tbl[i].clr; fcw_load = tbl[i].ld;
            fcw_in = tbl[i].fcw; phase_off = tbl[i].off;
            tick();
            chk($sformatf("tbl%0d_csb", i), ram_csb, tbl[i].e_csb);
            chk($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), sample_valid, tbl[i].e_vld);
            chk($sformatf("tbl%0d_sample", i), sample_out, tbl[i].e_smp);
        end
        en = 1'b0; clr = 1'b0; fcw_load = 1'b0;
        tick(); tick(); tick();

`ifndef NCO_QUARTER_WAVE_EN
        // Long run across the table wrap
        en = 1'b0; clr = 1'b1; fcw_load = 1'b1; fcw_in = 24'h010000; phase_off = '0;
        tick();
        clr = 1'b0; fcw_load = 1'b0; en = 1'b1;
        vcnt = 0; addr_wraps = 0; smp_wraps = 0;
        prev_addr = ram_addr; prev_smp = sample_out; prev_v = 1'b0;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (prev_addr == 8'hFF && ram_addr == 8'h00) addr_wraps++;
            if (sample_valid) begin
                vcnt++;
                if (prev_v && prev_smp == 16'hFFFF && sample_out == 16'h0000) smp_wraps++;
                prev_v = 1'b1;
            end
            prev_addr = ram_addr;
            prev_smp = sample_out;
        end
        chk("wrap_valid_count", vcnt, 258);
        chk("wrap_addr_seen", addr_wraps, 1);
        chk("wrap_sample_seen", smp_wraps, 1);
        en = 1'b0;
        tick(); tick(); tick();
`endif

        // Mid-run clear, then reset with reads in flight
        en = 1'b1; clr = 1'b0; fcw_load = 1'b1; fcw_in = 24'h010000; phase_off = '0;
        tick();
        fcw_load = 1'b0;
        tick(); tick(); tick();
        clr = 1'b1;
        tick();
        chk("clr_csb", ram_csb, 1'b1);
        clr = 1'b0;
        tick();
        chk("after_clr_addr", ram_addr, 8'h00);
        chk("after_clr_csb", ram_csb, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_csb", ram_csb, 1'b1);
        chk("rst_addr", ram_addr, 8'h00);
        rst_n = 1'b1; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_valid", sample_valid, 1'b0);
            chk("post_rst_sample", sample_out, 16'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
